// File: rtl/alu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM state
// encoding and a small op-decoding helper.
package alu_pkg;

  // 3-bit op encoding presented on i_op
  localparam logic [2:0] MD_OP_MULT  = 3'd0;
  localparam logic [2:0] MD_OP_MULTU = 3'd1;
  localparam logic [2:0] MD_OP_DIV   = 3'd2;
  localparam logic [2:0] MD_OP_DIVU  = 3'd3;
  localparam logic [2:0] MD_OP_MTHI  = 3'd4;
  localparam logic [2:0] MD_OP_MTLO  = 3'd5;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // True for the signed arithmetic ops (MULT, DIV)
  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_DIV);
  endfunction

  // True for the ops that run the iterative datapath (MULT..DIVU)
  function automatic logic md_is_arith(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negation. Used both to take operand
// magnitudes before an operation and to restore result signs afterwards.
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  // Negate when requested; the most-negative value maps to itself, which
  // is exactly the unsigned magnitude 2^(W-1) the datapath expects.
  always_comb begin
    res = neg ? (W'(0) - val) : val;
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// One datapath bit per clock: WIDTH iterations in RUN followed by a single
// FIX cycle that sign-corrects and writes HI/LO.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  // FSM and control state
  logic [1:0]         state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               is_div_reg;
  logic               neg_q_reg;     // negate product / quotient
  logic               neg_r_reg;     // negate remainder (dividend sign)
  logic               dz_pend_reg;   // divide by zero detected at start
  logic               done_reg;
  logic               div_zero_reg;

  // Datapath state. acc_reg holds {partial product, multiplier} for a
  // multiply and {remainder, dividend/quotient} for a divide; opb_reg holds
  // the multiplicand or the divisor magnitude.
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   opb_reg;
  logic [WIDTH-1:0]   a_raw_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;

  // Operand magnitudes: index 0 is A, index 1 is B
  logic [1:0][WIDTH-1:0] opnd_raw;
  logic [1:0][WIDTH-1:0] opnd_mag;
  logic [1:0]            opnd_neg;
  logic                  op_signed;

  assign op_signed   = md_is_signed(i_op);
  assign opnd_raw[0] = i_A;
  assign opnd_raw[1] = i_B;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
      assign opnd_neg[gi] = op_signed & opnd_raw[gi][WIDTH-1];
      md_sign_fix #(.W(WIDTH)) u_mag (
        .val (opnd_raw[gi]),
        .neg (opnd_neg[gi]),
        .res (opnd_mag[gi])
      );
    end
  endgenerate

  // Result sign correction
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  md_sign_fix #(.W(2*WIDTH)) u_prod_fix (
    .val (acc_reg),
    .neg (neg_q_reg),
    .res (prod_fix)
  );

  md_sign_fix #(.W(WIDTH)) u_quo_fix (
    .val (acc_reg[WIDTH-1:0]),
    .neg (neg_q_reg),
    .res (quo_fix)
  );

  md_sign_fix #(.W(WIDTH)) u_rem_fix (
    .val (acc_reg[2*WIDTH-1:WIDTH]),
    .neg (neg_r_reg),
    .res (rem_fix)
  );

  // One iteration of either algorithm
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] div_next;

  // Shift-add multiply step and restoring shift-subtract divide step
  always_comb begin
    // Multiply: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right; the
    // carry out of the add becomes the new top bit.
    mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
             + (acc_reg[0] ? {1'b0, opb_reg} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

    // Divide: bring the next dividend bit into the remainder. The shifted
    // remainder can need WIDTH+1 bits before the compare.
    div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_reg};
    div_ge    = (div_shift >= {1'b0, opb_reg});
    rem_new   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_next  = {rem_new, acc_reg[WIDTH-2:0], div_ge};
  end

  // Control FSM, datapath registers and HI/LO update
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      dz_pend_reg  <= 1'b0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
      acc_reg      <= '0;
      opb_reg      <= '0;
      a_raw_reg    <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (i_start) begin
            if (md_is_arith(i_op)) begin
              is_div_reg   <= i_op[1];
              neg_q_reg    <= opnd_neg[0] ^ opnd_neg[1];
              neg_r_reg    <= opnd_neg[0];
              dz_pend_reg  <= i_op[1] && (i_B == '0);
              a_raw_reg    <= i_A;
              div_zero_reg <= 1'b0;
              cnt_reg      <= CNT_W'(WIDTH);
              state_reg    <= ST_RUN;
              if (i_op[1]) begin
                acc_reg <= {{WIDTH{1'b0}}, opnd_mag[0]};
                opb_reg <= opnd_mag[1];
              end else begin
                acc_reg <= {{WIDTH{1'b0}}, opnd_mag[1]};
                opb_reg <= opnd_mag[0];
              end
            end else if (i_op == MD_OP_MTHI) begin
              hi_reg   <= i_A;
              done_reg <= 1'b1;
            end else if (i_op == MD_OP_MTLO) begin
              lo_reg   <= i_A;
              done_reg <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          acc_reg <= is_div_reg ? div_next : mul_next;
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (is_div_reg) begin
            if (dz_pend_reg) begin
              // Divide by zero: defined result instead of a trap
              lo_reg       <= '1;
              hi_reg       <= a_raw_reg;
              div_zero_reg <= 1'b1;
            end else begin
              lo_reg <= quo_fix;
              hi_reg <= rem_fix;
            end
          end else begin
            {hi_reg, lo_reg} <= prod_fix;
          end
          done_reg  <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy     = (state_reg == ST_RUN) || (state_reg == ST_FIX);
  assign o_done     = done_reg;
  assign o_div_zero = div_zero_reg;
  assign o_hi       = hi_reg;
  assign o_lo       = lo_reg;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv (WIDTH=32): arithmetic results, latency,
// divide-by-zero, MTHI/MTLO, ignored starts and mid-operation reset.
module tb_alu_muldiv;

  localparam int W   = 32;
  localparam int LAT = W + 1;   // edges after the start edge until done

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  alu_muldiv #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_op       (op),
    .i_A        (a),
    .i_B        (b),
    .o_busy     (busy),
    .o_done     (done),
    .o_div_zero (div_zero),
    .o_hi       (hi),
    .o_lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one arithmetic op and wait (bounded) for done; lat counts edges
  // after the start edge, sampled on falling edges.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] va,
                        input logic [W-1:0] vb, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    check("busy_rise", 64'(busy), 64'd1);
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int pulses;
    rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_hi",   64'(hi),       64'd0);
    check("rst_lo",   64'(lo),       64'd0);
    check("rst_busy", 64'(busy),     64'd0);
    check("rst_done", 64'(done),     64'd0);
    check("rst_dz",   64'(div_zero), 64'd0);

    // MULTU max x max
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("multu_lat",  64'(lat),  64'(LAT));
    check("multu_busy", 64'(busy), 64'd0);
    check("multu_hi",   64'(hi),   64'hFFFF_FFFE);
    check("multu_lo",   64'(lo),   64'h0000_0001);
    $display("MULTU ffffffff*ffffffff lat=%0d hi=%h lo=%h", lat, hi, lo);
    @(negedge clk);
    check("multu_done_pulse", 64'(done), 64'd0);

    // MULT -7 x 6
    run_op(3'd0, 32'hFFFF_FFF9, 32'd6, lat);
    check("mult_lat", 64'(lat), 64'(LAT));
    check("mult_hi",  64'(hi),  64'hFFFF_FFFF);
    check("mult_lo",  64'(lo),  64'hFFFF_FFD6);
    $display("MULT -7*6 hi=%h lo=%h", hi, lo);

    // MULT most-negative squared
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, lat);
    check("multmn_hi", 64'(hi), 64'h4000_0000);
    check("multmn_lo", 64'(lo), 64'h0000_0000);
    $display("MULT 80000000*80000000 hi=%h lo=%h", hi, lo);

    // DIV -7 / 2
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, lat);
    check("div_lat", 64'(lat), 64'(LAT));
    check("div_lo",  64'(lo),  64'hFFFF_FFFD);
    check("div_hi",  64'(hi),  64'hFFFF_FFFF);
    check("div_dz",  64'(div_zero), 64'd0);
    $display("DIV -7/2 hi=%h lo=%h", hi, lo);

    // DIVU 100 / 7
    run_op(3'd3, 32'd100, 32'd7, lat);
    check("divu_lo", 64'(lo), 64'd14);
    check("divu_hi", 64'(hi), 64'd2);
    $display("DIVU 100/7 hi=%h lo=%h", hi, lo);

    // DIV most-negative / -1
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("divmn_lo", 64'(lo), 64'h8000_0000);
    check("divmn_hi", 64'(hi), 64'h0000_0000);
    $display("DIV 80000000/-1 hi=%h lo=%h", hi, lo);

    // DIVU by zero
    run_op(3'd3, 32'h0000_1234, 32'd0, lat);
    check("dz_lat", 64'(lat),      64'(LAT));
    check("dz_lo",  64'(lo),       64'hFFFF_FFFF);
    check("dz_hi",  64'(hi),       64'h0000_1234);
    check("dz_flag", 64'(div_zero), 64'd1);
    $display("DIVU 1234/0 hi=%h lo=%h dz=%b", hi, lo, div_zero);
    @(negedge clk);
    check("dz_sticky", 64'(div_zero), 64'd1);

    // MULTU 3 x 5 clears the flag at start
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    check("dz_clear", 64'(div_zero), 64'd0);
    lat = 0;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("m35_lo", 64'(lo), 64'd15);
    check("m35_hi", 64'(hi), 64'd0);
    $display("MULTU 3*5 hi=%h lo=%h dz=%b", hi, lo, div_zero);

    // Op 6 is a no-op
    @(negedge clk);
    start = 1'b1; op = 3'd6; a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    check("nop_done", 64'(done), 64'd0);
    check("nop_busy", 64'(busy), 64'd0);
    check("nop_lo",   64'(lo),   64'd15);
    $display("NOP op6 done=%b busy=%b", done, busy);

    // MTHI then MTLO back to back
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'hAAAA_0000;
    @(negedge clk);
    check("mthi_hi",   64'(hi),   64'hAAAA_0000);
    check("mthi_lo",   64'(lo),   64'd15);
    check("mthi_done", 64'(done), 64'd1);
    check("mthi_busy", 64'(busy), 64'd0);
    op = 3'd5; a = 32'h0000_5555;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_lo",   64'(lo),   64'h0000_5555);
    check("mtlo_hi",   64'(hi),   64'hAAAA_0000);
    check("mtlo_done", 64'(done), 64'd1);
    check("mtlo_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("mt_done_drop", 64'(done), 64'd0);
    $display("MTHI/MTLO hi=%h lo=%h", hi, lo);

    // MULT 3 x 4 with a stray MTHI start at cycle 10
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
    pulses = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (done) pulses++;
      start = (c == 10);
      if (c == 10) begin
        op = 3'd4; a = 32'hDEAD_0000;
      end
    end
    start = 1'b0;
    check("busy_start_pulses", 64'(pulses), 64'd1);
    check("busy_start_hi",     64'(hi),     64'd0);
    check("busy_start_lo",     64'(lo),     64'd12);
    $display("MULT 3*4 with ignored start pulses=%0d hi=%h lo=%h", pulses, hi, lo);

    // Reset in the middle of a DIV
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_hi",   64'(hi),   64'd0);
    check("mrst_lo",   64'(lo),   64'd0);
    check("mrst_done", 64'(done), 64'd0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("mrst_no_done", 64'(pulses), 64'd0);
    $display("RESET mid-DIV busy=%b hi=%h lo=%h late_done=%0d", busy, hi, lo, pulses);

    // Fresh MULTU 2 x 3 after reset
    run_op(3'd1, 32'd2, 32'd3, lat);
    check("post_lat", 64'(lat), 64'(LAT));
    check("post_lo",  64'(lo),  64'd6);
    check("post_hi",  64'(hi),  64'd0);
    $display("MULTU 2*3 hi=%h lo=%h", hi, lo);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised, multi-cycle multiply/divide unit with HI/LO result registers.
- Sits beside the single-cycle ALU in the MIPS execute stage and serves MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Iterative radix-2: processes one bit per clock, so a full operation takes WIDTH+1 cycles.
- Uses a start/busy/done handshake so the pipeline can stall on HI/LO reads while busy.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be ≥4 and even.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- i_clk  in  1  rising-edge clock
- i_rst  in  1  synchronous reset, active-high
- i_start  in  1  request; sampled only in IDLE
- i_op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6-7=no-op
- i_A  in  WIDTH  multiplicand / dividend / MTHI-MTLO source
- i_B  in  WIDTH  multiplier / divisor
- o_busy  out  1  high while RUN or FIX
- o_done  out  1  one-cycle pulse; HI/LO valid and final
- o_div_zero  out  1  sticky per operation; set by DIV/DIVU with i_B==0
- o_hi  out  WIDTH  HI register
- o_lo  out  WIDTH  LO register

Behaviour:
- Reset: state=IDLE; o_hi=0, o_lo=0, o_busy=0, o_done=0, o_div_zero=0; counter cleared. Reset in any state aborts the operation with no partial HI/LO update.
- FSM states are IDLE, RUN and FIX.
- IDLE, i_start with op 0-3:
  - Latch magnitudes of i_A and i_B. Signed ops take the two's-complement magnitude; unsigned ops use the raw values.
  - Latch result sign flags and the op.
  - Clear o_div_zero, load the counter with WIDTH, go to RUN.
- IDLE, i_start with op 4/5: write i_A into o_hi (4) or o_lo (5) on that edge. Stay in IDLE. No busy, and o_done pulses next cycle.
- IDLE, i_start with op 6/7: ignored. No state change, no done pulse.
- RUN: one iteration per cycle; decrement the counter; go to FIX when the counter reaches 1.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract. Each step shifts the remainder left by one and brings in the next dividend bit. If the remainder ≥ divisor, subtract and shift in quotient 1; otherwise shift in 0.
- FIX, one cycle:
  - Apply sign correction and write {o_hi,o_lo}. The multiply writes the 2*WIDTH product. The divide writes o_lo=quotient and o_hi=remainder.
  - Assert o_done for that single cycle, then return to IDLE.
- Latency: i_start sampled at edge T. o_busy is high from T+1 through T+WIDTH+1. o_done and the new HI/LO are visible after edge T+WIDTH+1, with o_busy low in the same cycle.
- i_start while o_busy: ignored; no queueing.
- HI/LO hold their values between operations and during RUN; they are updated only in FIX, or by MTHI/MTLO.
- Signed multiply: product is negated iff the operand signs differ. The most-negative × most-negative case must give a correct 2*WIDTH result (WIDTH=32: 0x40000000_00000000).
- Signed divide:
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Most-negative / -1: o_lo=most-negative, o_hi=0; no trap.
- Divide by zero (DIV or DIVU):
  - Full WIDTH+1 latency still applies.
  - Result: o_lo = all-ones, o_hi = i_A as latched. o_div_zero=1 from the FIX edge until the next op start.
- Multiply ops never set o_div_zero.

Decomposition:
- Shared package alu_pkg holds:
  - MD_OP_* localparams for the 3-bit op encoding;
  - state encodings ST_IDLE, ST_RUN and ST_FIX.
- One natural sub-module: md_sign_fix. It is combinational and handles magnitude extraction and final negation, so the same logic serves both operand preparation and result correction.
- Datapath and FSM stay in alu_muldiv.

Test Plan:
- MULTU, WIDTH=32, A=0xFFFFFFFF, B=0xFFFFFFFF -> after 33 cycles o_done=1, o_hi=0xFFFFFFFE, o_lo=0x00000001, o_busy low in the done cycle.
- MULT A=-7 (0xFFFFFFF9), B=6 -> o_hi=0xFFFFFFFF, o_lo=0xFFFFFFD6; and A=B=0x80000000 -> o_hi=0x40000000, o_lo=0.
- DIV A=-7, B=2 -> o_lo=0xFFFFFFFD (-3), o_hi=0xFFFFFFFF (-1). DIVU A=100, B=7 -> o_lo=14, o_hi=2. DIV 0x80000000/-1 -> o_lo=0x80000000, o_hi=0.
- DIVU A=0x1234, B=0 -> o_lo=0xFFFFFFFF, o_hi=0x1234, o_div_zero=1. A following MULTU 3×5 clears o_div_zero at start and gives o_lo=15.
- MTHI 0xAAAA0000 then MTLO 0x5555 in back-to-back cycles -> o_hi and o_lo update one edge each, o_busy never asserts. An i_start pulsed at cycle 10 of a running MULT is ignored: the result is unchanged and only one o_done pulse occurs.
- i_rst asserted mid-DIV (cycle 15) -> the next edge gives IDLE, o_hi=o_lo=0 and no o_done. A fresh MULTU 2×3 then completes normally with o_lo=6.
